// File: rtl/dct_tbuf_pkg.sv
// Shared types and index helpers for the DCT transpose buffer.
// An entry index is row-major: idx = {row, col}.
package dct_tbuf_pkg;

    localparam int COEF_W      = 10;
    localparam int BLK_DIM     = 8;
    localparam int BLK_ENTRIES = BLK_DIM * BLK_DIM;

    typedef logic [5:0]               idx_t;
    typedef logic signed [COEF_W-1:0] coef_t;

    function automatic logic [2:0] row_of(idx_t i);
        return i[5:3];
    endfunction

    function automatic logic [2:0] col_of(idx_t i);
        return i[2:0];
    endfunction

endpackage

// File: rtl/dct_tbuf_bank.sv
// One 64-entry coefficient bank: synchronous write, combinational read.
// Cleared by async reset or by a synchronous clear.
module dct_tbuf_bank
    import dct_tbuf_pkg::*;
#(
    parameter int W     = COEF_W,
    parameter int DEPTH = BLK_ENTRIES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr_en,
    input  idx_t         wr_addr,
    input  logic [W-1:0] wr_data,
    input  idx_t         rd_addr,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer: row-major blocks in, column-major blocks out.
// One bank fills while the other drains; full[] flags arbitrate ownership.
module dct_transpose_buffer
    import dct_tbuf_pkg::*;
#(
    parameter int SIZE = 10,
    parameter int DIM  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [SIZE-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [SIZE-1:0] out_data,
    output logic                   out_last
);

    localparam int   ENTRIES  = DIM * DIM;
    localparam idx_t LAST_IDX = idx_t'(ENTRIES - 1);

    logic [1:0]      full;
    logic            wr_bank;
    logic            rd_bank;
    idx_t            wr_cnt;
    idx_t            rd_cnt;
    logic            wr_acc;
    logic            rd_acc;
    idx_t            rd_addr;
    logic [SIZE-1:0] rd_data0;
    logic [SIZE-1:0] rd_data1;

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign wr_acc    = in_valid && in_ready;
    assign rd_acc    = out_valid && out_ready;
    assign out_last  = out_valid && (rd_cnt == LAST_IDX);

    // Read walks columns: rd_cnt[5:3] picks the column, rd_cnt[2:0] the row.
    assign rd_addr  = {col_of(rd_cnt), row_of(rd_cnt)};
    assign out_data = rd_bank ? rd_data1 : rd_data0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else if (clr) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            // wr_bank never equals rd_bank while both complete, so the two
            // full[] updates always land on different bits.
            if (wr_acc) begin
                wr_cnt <= wr_cnt + 6'd1;
                if (wr_cnt == LAST_IDX) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (rd_acc) begin
                rd_cnt <= rd_cnt + 6'd1;
                if (rd_cnt == LAST_IDX) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end

    dct_tbuf_bank #(.W(SIZE), .DEPTH(ENTRIES)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr_en   (wr_acc && !wr_bank),
        .wr_addr (wr_cnt),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data0)
    );

    dct_tbuf_bank #(.W(SIZE), .DEPTH(ENTRIES)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr_en   (wr_acc && wr_bank),
        .wr_addr (wr_cnt),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data1)
    );

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed and randomized-handshake bench for dct_transpose_buffer.
// A value-level scoreboard holds the transposed blocks awaiting output.
module tb_dct_transpose_buffer;
    import dct_tbuf_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  clr = 1'b0;
    logic  in_valid = 1'b0;
    logic  out_ready = 1'b0;
    logic  in_ready, out_valid, out_last;
    coef_t in_data = '0;
    coef_t out_data;

    always #5 clk = ~clk;

    dct_transpose_buffer #(.SIZE(10), .DIM(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    coef_t src_q[$];
    coef_t exp_q[$];
    coef_t blk[64];
    int    wcnt = 0;
    int    rcnt = 0;
    logic  prev_stall = 1'b0;
    coef_t prev_data = '0;
    logic  prev_last = 1'b0;

    task automatic check(string tag, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        src_q.delete();
        exp_q.delete();
        wcnt       = 0;
        rcnt       = 0;
        prev_stall = 1'b0;
    endtask

    // kind 0: value = 8*row+col, kind 1: random, kind 2: signed extremes
    task automatic push_block(int kind, int n);
        coef_t ext[4];
        ext[0] = -10'sd512;
        ext[1] = 10'sd511;
        ext[2] = -10'sd1;
        ext[3] = 10'sd0;
        for (int k = 0; k < n; k++) begin
            case (kind)
                0:       src_q.push_back(coef_t'(k));
                1:       src_q.push_back(coef_t'($urandom_range(1023)));
                default: src_q.push_back(ext[(k + k / 8) % 4]);
            endcase
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(int vpct, int rpct);
        int   full_banks;
        logic acc_in, acc_out;
        in_valid  = (src_q.size() != 0) && (int'($urandom_range(99)) < vpct);
        in_data   = (src_q.size() != 0) ? src_q[0] : '0;
        out_ready = int'($urandom_range(99)) < rpct;
        #1;
        full_banks = (exp_q.size() + 63) / 64;
        check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
        check("in_ready", int'(in_ready), int'(full_banks < 2));
        if (out_valid && exp_q.size() != 0) begin
            check("out_data", int'(out_data), int'(exp_q[0]));
            check("out_last", int'(out_last), int'(rcnt == 63));
        end
        if (prev_stall) begin
            check("hold_data", int'(out_data), int'(prev_data));
            check("hold_last", int'(out_last), int'(prev_last));
        end
        acc_in     = in_valid && in_ready;
        acc_out    = out_valid && out_ready;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        @(posedge clk);
        #1;
        if (acc_in) begin
            blk[wcnt] = src_q.pop_front();
            wcnt++;
            if (wcnt == 64) begin
                for (int k = 0; k < 64; k++) exp_q.push_back(blk[(k % 8) * 8 + k / 8]);
                wcnt = 0;
            end
        end
        if (acc_out) begin
            void'(exp_q.pop_front());
            rcnt = (rcnt + 1) % 64;
        end
    endtask

    task automatic drain(int vpct, int rpct, string tag);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < 5000) begin
            step(vpct, rpct);
            n++;
        end
        check(tag, src_q.size() + exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_out_last"}, int'(out_last), 0);
    endtask

    // Block 1 fully written and half read, 30 entries of block 2 written.
    task automatic setup_midop();
        push_block(1, 64);
        push_block(1, 30);
        for (int i = 0; i < 300 && src_q.size() != 0; i++) step(100, 0);
        check("midop_written", src_q.size(), 0);
        repeat (32) step(0, 100);
        check("midop_remaining", exp_q.size(), 32);
    endtask

    initial begin
        #1 rst = 1'b0;
        #11;
        check_reset_outputs("por");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // single block 8*row+col: output 0,8,16,...,56,1,9,...,63
        push_block(0, 64);
        drain(100, 100, "single_drain");

        // three blocks with the consumer stalled: two banks fill, third waits
        push_block(1, 64);
        push_block(1, 64);
        push_block(1, 64);
        repeat (140) step(100, 0);
        check("stall_accepted", 192 - src_q.size(), 128);
        check("stall_in_ready", int'(in_ready), 0);
        drain(100, 100, "three_drain");

        for (int b = 0; b < 10; b++) push_block(1, 64);
        drain(70, 50, "random_drain");

        push_block(2, 64);
        drain(100, 60, "extreme_drain");

        // async reset mid-cycle, with in_valid held across the reset
        setup_midop();
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_clear();
        push_block(1, 64);
        in_valid = 1'b1;
        in_data  = src_q[0];
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        rst = 1'b1;
        drain(100, 100, "rst_recover");

        // synchronous clear mid-operation
        setup_midop();
        clr       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check_reset_outputs("clr_mid");
        model_clear();
        push_block(0, 64);
        drain(100, 100, "clr_recover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dct_transpose_buffer.md
Name: dct_transpose_buffer

Overview:
Ping-pong 8x8 transpose buffer between DCT stage 1 (row pass) and stage 2 (column pass). It accepts 64 signed coefficients per block in row-major order and returns them in column-major order. Two 64-entry banks let one block be written while the previous block is read out. Both sides use a valid/ready handshake.

Parameters:
SIZE, 10, coefficient width in bits (signed), matches stage-1 register width
DIM, 8, block dimension; block holds DIM*DIM = 64 entries (fixed at 8 for this revision)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low (rst==0 resets all state immediately)
clr  input  1  synchronous clear: same effect as reset on the next edge
in_valid  input  1  stage 1 presents in_data
in_ready  output  1  buffer can accept in_data this cycle
in_data  input  SIZE  signed coefficient, row-major within block
out_valid  output  1  out_data holds a valid coefficient
out_ready  input  1  stage 2 accepts out_data this cycle
out_data  output  SIZE  signed coefficient, column-major within block
out_last  output  1  high with the 64th (final) output of a block

Behaviour:
- State: bank0/bank1 (64 x SIZE flops each), full[1:0], wr_bank, wr_cnt[5:0], rd_bank, rd_cnt[5:0].
- Reset (rst low, or clr high at an edge): full=0, wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, all bank entries=0. Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0.
- in_ready = !full[wr_bank]. This is a combinational decode of registered state and does not depend on in_valid.
- Write accept = in_valid && in_ready:
  - bank[wr_bank][row=wr_cnt[5:3]][col=wr_cnt[2:0]] <= in_data
  - wr_cnt increments.
  - On the accept with wr_cnt==63: full[wr_bank]<=1, wr_bank toggles, wr_cnt wraps to 0.
- out_valid = full[rd_bank].
- out_data = bank[rd_bank][row=rd_cnt[2:0]][col=rd_cnt[5:3]], a combinational read of flops.
- out_last = out_valid && rd_cnt==63.
- Read accept = out_valid && out_ready:
  - rd_cnt increments.
  - On the accept with rd_cnt==63: full[rd_bank]<=0, rd_bank toggles, rd_cnt wraps to 0.
- Latency: the 64th write accepted at edge N gives out_valid=1 after edge N, with the first output bank[r0][c0] presented immediately. Data passes through unmodified: no arithmetic, no saturation, sign preserved.
- Back-pressure: while out_valid && !out_ready, out_data and out_last hold stable.
- Both banks full: in_ready=0; input samples stall without loss.
- Simultaneous final read and write targeting the same bank: impossible by construction. in_ready is derived from the pre-edge full flag, so a freed bank accepts writes from the following cycle.
- Simultaneous final write to one bank and final read of the other: both flag updates take effect on the same edge.
- Reset mid-block: a partial block is discarded and counters restart at 0. Holding in_valid across reset is legal; the first accept after reset is entry 0.
- in_valid may drop mid-block; the block completes when 64 accepts have occurred.

Decomposition:
- Package dct_tbuf_pkg:
  - BLK_DIM=8, BLK_ENTRIES=64
  - typedef idx_t logic [5:0]
  - typedef coef_t logic signed [SIZE-1:0] (SIZE default 10)
  - functions row_of(idx_t) and col_of(idx_t)
- Sub-module dct_tbuf_bank:
  - 64-entry SIZE-wide register bank with async active-low reset, wr_en, 6-bit write address and 6-bit combinational read address.
  - Instantiated twice; top level holds the counters, flags and muxes.

Test Plan:
- Reset check: assert rst=0 mid-cycle -> in_ready=1, out_valid=0, out_data=0, out_last=0 immediately, without waiting for a clock edge.
- Single block, value = 8*row+col (0..63), out_ready=1:
  - out_valid rises the cycle after the 64th accept.
  - Output sequence is 0,8,16,...,56,1,9,...,63.
  - out_last is high only with 63.
- Three blocks back-to-back with out_ready=0:
  - in_ready falls after accept #128; sample #129 is held.
  - Raise out_ready: after 64 reads, in_ready=1 on the next cycle.
  - Block 2 then block 3 output in order, with correct transpose.
- Random out_ready (50%) and random in_valid gaps over 10 blocks:
  - Scoreboard matches transpose with no loss or duplication.
  - out_data is stable during stalls.
- Extremes: block containing -512, 511, -1, 0 (SIZE=10) -> identical signed values at transposed positions.
- Reset and clear mid-operation:
  - Reset after 30 samples of block 2 while block 1 is half read -> all state cleared; next full block transposes correctly from entry 0.
  - Repeat using clr=1 for one cycle -> same result.
